instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Fetch stage directly downstream of the program counter. Samples prog_ctr each cycle and
//  issues a synchronous read to instruction memory. Pairs each returned instruction with its
//  PC tag and buffers the pair in a small FIFO for decode.
//  Drives pc_hold back to the PC increment enable, and flushes on a taken absolute jump.
// PARAMETERS
//  D      12  PC / instruction-address width
//  IW      9  instruction word width
//  DEPTH   4  queue entries; power of two, >= 2
// PORTS
//  clk          in   1      single clock; all state updates on posedge
//  reset        in   1      synchronous, active-high; clears all state
//  prog_ctr     in   D      current PC value from the program counter
//  flush        in   1      taken jump this cycle (same signal as PC absjump_en)
//  pc_hold      out  1      1 = PC must not advance this cycle
//  imem_addr    out  D      instruction memory read address
//  imem_rd      out  1      read request; data valid on imem_rdata the NEXT cycle
//  imem_rdata   in   IW     instruction memory read data
//  instr_valid  out  1      queue head holds a valid instruction
//  instr        out  IW     head instruction
//  instr_pc     out  D      PC of head instruction
//  instr_ready  in   1      decode accepts head when instr_valid && instr_ready
// BEHAVIOUR
//  Reset: count=0, rd/wr ptrs=0, inflight=0, instr_valid=0, pc_hold=0, imem_rd=0,
//   instr=0, instr_pc=0. Reset wins over every other input in the same cycle.
//  Request (combinational): imem_addr=prog_ctr always.
//   imem_rd = !reset && !flush && !pc_hold.
//  Response: inflight <= imem_rd; tag <= prog_ctr registered with it.
//   When inflight=1 (and no flush this cycle), push {tag, imem_rdata} into queue.
//   Latency: PC value at cycle t -> instr_valid at t+2 when queue empty.
//  Credit rule: pc_hold = (count + inflight >= DEPTH), with pop this cycle not credited.
//   This rule guarantees a push never hits a full queue; an overflow is an assertion error.
//  Pop: when instr_valid && instr_ready, advance rd ptr.
//   Push+pop in the same cycle leaves count unchanged (legal at any count, incl. DEPTH).
//  Pop on empty is impossible: instr_valid = (count != 0). instr/instr_pc are driven from
//   the head entry and hold their value while !instr_ready.
//  Flush (cycle t): count<=0, ptrs<=0, inflight<=0, no push of the response arriving at t,
//   no request at t. The PC loads its target at t+1 and fetch resumes normally from it.
//   Flush overrides a simultaneous pop (decode must ignore a pop made in a flush cycle).
//  Pointer wrap: log2(DEPTH)-bit ptrs wrap naturally; count is log2(DEPTH)+1 bits,
//   range 0..DEPTH.
//  Widths: prog_ctr/imem_addr/instr_pc are all D bits, with no truncation or extension.
//  Reset mid-stream: in-flight response discarded, queue emptied, outputs at reset values
//   the next cycle.
// STRUCTURE
//  jay_pkg: localparams D_DEF=12, IW_DEF=9; typedef struct packed {logic [D-1:0] pc;
//   logic [IW-1:0] instr;} fetch_entry_t. Shared by PC and decode.
//  Sub-module fetch_fifo #(DEPTH, type T=fetch_entry_t): sync FIFO with push, pop, clear,
//   head, count; clear has priority over push/pop.
//  Top: request/inflight/tag registers, credit logic, flush control, fetch_fifo instance.
// TESTING
//  1 reset, prog_ctr=0,1,2.., ready=1 -> instr_valid at cycle 2; instr_pc=0,1,2 in order;
//    instr = mem[pc].
//  2 ready=0 for 10 cycles -> count reaches 4; pc_hold=1 from the cycle count+inflight=4;
//    no push past 4.
//  3 full queue, ready=1 one cycle -> one pop; pc_hold drops; exactly one new entry
//    (pc=4) arrives 2 cycles later.
//  4 flush at t with 3 entries + inflight -> instr_valid=0 at t+1; stale pc never emerges;
//    next instr_pc = jump target.
//  5 reset asserted with imem_rd=1 pending -> next cycle instr_valid=0, count=0;
//    rdata at that edge is dropped.
//  6 push+pop each cycle at count=2, 20 cycles -> count stays 2; pointers wrap past 3;
//    PCs in strict order.

Source files
------------

// File: rtl/jay_pkg.sv
// Types and defaults shared by the program counter, fetch queue and decode.
// fetch_entry_t pairs a fetched instruction with the PC it was read from.
package jay_pkg;

    localparam int D_DEF     = 12;
    localparam int IW_DEF    = 9;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic [D_DEF-1:0]  pc;
        logic [IW_DEF-1:0] instr;
    } fetch_entry_t;

    // True when occupied slots plus the outstanding read use up every queue entry.
    function automatic logic credit_exhausted(
        input logic [31:0] count,
        input logic        inflight,
        input logic [31:0] depth
    );
        return (count + {31'd0, inflight}) >= depth;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_chk.sv
// Protocol checker for the fetch queue: the credit scheme must make overflow
// and pop-on-empty unreachable.
module instr_fetch_queue_chk #(
    parameter int DEPTH = 4
) (
    input logic                   clk,
    input logic                   reset,
    input logic                   push_i,
    input logic                   pop_i,
    input logic [$clog2(DEPTH):0] count_i
);

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (push_i && !pop_i) |-> (32'(count_i) < 32'(DEPTH)))
        else $error("fetch queue overflow");

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        pop_i |-> (count_i != '0))
        else $error("fetch queue pop on empty");

endmodule

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Synchronous FIFO for fetched entries. Clear has priority over push and pop;
// reset additionally zeroes the storage so the head reads as zero out of reset.
module fetch_fifo
    import jay_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  T                           push_data_i,
    input  logic                       pop_i,
    output T                           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    T              mem_q [DEPTH];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers and entry storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !clear_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues one instruction-memory read per PC, tags the response with
// its PC and queues it for decode; holds the PC when queue credit runs out.
module instr_fetch_queue
    import jay_pkg::*;
#(
    parameter int D     = D_DEF,
    parameter int IW    = IW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [D-1:0]  prog_ctr,
    input  logic          flush,
    output logic          pc_hold,
    output logic [D-1:0]  imem_addr,
    output logic          imem_rd,
    input  logic [IW-1:0] imem_rdata,
    output logic          instr_valid,
    output logic [IW-1:0] instr,
    output logic [D-1:0]  instr_pc,
    input  logic          instr_ready
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [D-1:0]  pc;
        logic [IW-1:0] instr;
    } entry_t;

    logic         inflight_q;
    logic         inflight_d;
    logic [D-1:0] tag_q;
    logic [D-1:0] tag_d;

    logic         hold_s;
    logic         rd_req_s;
    logic         push_s;
    logic         pop_s;
    logic         valid_s;
    logic [AW:0]  count_s;
    entry_t       push_data_s;
    entry_t       head_s;

    // Credit, request and queue-control decisions for this cycle.
    always_comb begin
        valid_s  = (count_s != '0);
        // A pop this cycle is deliberately not credited: keeps the hold path off instr_ready.
        hold_s   = credit_exhausted(32'(count_s), inflight_q, 32'(DEPTH));
        rd_req_s = !reset && !flush && !hold_s;
        push_s   = inflight_q && !flush && !reset;
        pop_s    = valid_s && instr_ready && !flush;
        push_data_s.pc    = tag_q;
        push_data_s.instr = imem_rdata;
        inflight_d = rd_req_s;
        if (rd_req_s) begin
            tag_d = prog_ctr;
        end else begin
            tag_d = tag_q;
        end
    end

    // Outstanding-read flag and the PC tag that travels with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (flush),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (count_s)
    );

    instr_fetch_queue_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .count_i (count_s)
    );

    assign pc_hold     = hold_s;
    assign imem_addr   = prog_ctr;
    assign imem_rd     = rd_req_s;
    assign instr_valid = valid_s;
    assign instr       = head_s.instr;
    assign instr_pc    = head_s.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised and directed bench for instr_fetch_queue against a queue-based
// reference model of the fetch pipeline, program counter and instruction memory.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] prog_ctr;
    logic        flush;
    logic        pc_hold;
    logic [11:0] imem_addr;
    logic        imem_rd;
    logic [8:0]  imem_rdata;
    logic        instr_valid;
    logic [8:0]  instr;
    logic [11:0] instr_pc;
    logic        instr_ready;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [11:0] pc;
        logic [8:0]  ins;
    } ent_t;

    ent_t        q_m[$];
    bit          infl_m;
    logic [11:0] tag_m;
    logic [11:0] pc_m;
    bit          zero_head_m;

    instr_fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .prog_ctr    (prog_ctr),
        .flush       (flush),
        .pc_hold     (pc_hold),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] memf(input logic [11:0] a);
        logic [11:0] t;
        t = (a * 12'd37) ^ 12'h15B;
        return t[8:0] ^ {6'd0, a[11:9]};
    endfunction

    // Instruction memory: data for the address read at one edge appears after it; junk otherwise.
    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= memf(imem_addr);
        else         imem_rdata <= 9'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model, advance the model and the DUT.
    task automatic cycle(input bit rst, input bit fl, input bit rdy, input logic [11:0] tgt);
        int   occ;
        bit   hold_e;
        bit   rd_e;
        ent_t e;
        reset       = rst;
        flush       = fl;
        instr_ready = rdy;
        prog_ctr    = pc_m;
        #1;
        occ    = q_m.size() + (infl_m ? 1 : 0);
        hold_e = (occ >= 4);
        rd_e   = !rst && !fl && !hold_e;
        chk("pc_hold", 32'(pc_hold), 32'(hold_e));
        chk("imem_rd", 32'(imem_rd), 32'(rd_e));
        chk("imem_addr", 32'(imem_addr), 32'(pc_m));
        chk("instr_valid", 32'(instr_valid), 32'(q_m.size() != 0));
        if (q_m.size() != 0) begin
            chk("instr_pc", 32'(instr_pc), 32'(q_m[0].pc));
            chk("instr", 32'(instr), 32'(q_m[0].ins));
        end else if (zero_head_m) begin
            chk("rst_instr_pc", 32'(instr_pc), 32'd0);
            chk("rst_instr", 32'(instr), 32'd0);
        end
        if (rst) begin
            q_m.delete();
            infl_m      = 1'b0;
            pc_m        = 12'd0;
            zero_head_m = 1'b1;
        end else if (fl) begin
            q_m.delete();
            infl_m      = 1'b0;
            pc_m        = tgt;
            zero_head_m = 1'b0;
        end else begin
            zero_head_m = 1'b0;
            if (q_m.size() != 0 && rdy) void'(q_m.pop_front());
            if (infl_m) begin
                chk("no_overflow", 32'(q_m.size() < 4), 32'd1);
                e.pc  = tag_m;
                e.ins = memf(tag_m);
                q_m.push_back(e);
            end
            infl_m = rd_e;
            tag_m  = pc_m;
            if (!hold_e) pc_m = pc_m + 12'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        instr_ready = 1'b0;
        prog_ctr    = 12'd0;
        infl_m      = 1'b0;
        tag_m       = 12'd0;
        pc_m        = 12'd0;
        zero_head_m = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Latency from an empty queue and in-order delivery.
        cycle(1'b1, 1'b0, 1'b1, 12'd0);
        cycle(1'b0, 1'b0, 1'b1, 12'd0);
        chk("lat_c1_valid", 32'(instr_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 12'd0);
        chk("lat_c2_valid", 32'(instr_valid), 32'd1);
        chk("lat_c2_pc", 32'(instr_pc), 32'd0);
        repeat (6) cycle(1'b0, 1'b0, 1'b1, 12'd0);

        // Fill with decode stalled, then release exactly one entry.
        cycle(1'b1, 1'b0, 1'b0, 12'd0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 12'd0);
        chk("full_hold", 32'(pc_hold), 32'd1);
        chk("full_head_pc", 32'(instr_pc), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 12'd0);
        chk("pop_hold_drop", 32'(pc_hold), 32'd0);
        chk("pop_head_pc", 32'(instr_pc), 32'd1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 12'd0);
        chk("refill_hold", 32'(pc_hold), 32'd1);
        repeat (8) cycle(1'b0, 1'b0, 1'b1, 12'd0);

        // Flush with three entries queued and one read outstanding.
        cycle(1'b1, 1'b0, 1'b0, 12'd0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 12'd0);
        chk("pre_flush_valid", 32'(instr_valid), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 12'h5A0);
        chk("flush_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 6 && !instr_valid; i++) cycle(1'b0, 1'b0, 1'b1, 12'd0);
        chk("jump_valid", 32'(instr_valid), 32'd1);
        chk("jump_target_pc", 32'(instr_pc), 32'h5A0);
        repeat (4) cycle(1'b0, 1'b0, 1'b1, 12'd0);

        // Reset while a read is outstanding.
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 12'd0);
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 12'd0);
        chk("rst_mid_valid", 32'(instr_valid), 32'd0);
        chk("rst_mid_hold", 32'(pc_hold), 32'd0);

        // Steady push+pop at two entries; pointers wrap several times.
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 12'd0);
        repeat (20) cycle(1'b0, 1'b0, 1'b1, 12'd0);
        chk("steady_hold", 32'(pc_hold), 32'd0);
        chk("steady_valid", 32'(instr_valid), 32'd1);

        // Random traffic: stalls, flushes to random targets and occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 65, 12'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
